// File: rtl/host_msix_monitor_if.sv
// rtl/host_msix_monitor_if.sv - host write snoop, MSI-X table config, pending/event/counter bundle
interface host_msix_monitor_if #(
    parameter int NUM_VEC = 8,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
);
    logic               wr_valid;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [DATA_W-1:0]  cfg_data;
    logic               cfg_en;
    logic               cfg_mask;
    logic               clr_valid;
    logic [IDX_W-1:0]   clr_idx;
    logic [NUM_VEC-1:0] pending;
    logic               intr_any;
    logic               evt_valid;
    logic               evt_ready;
    logic [IDX_W-1:0]   evt_vec;
    logic               evt_ovf;
    logic               ovf_clr;
    logic [IDX_W-1:0]   cnt_idx;
    logic [CNT_W-1:0]   cnt_val;
    logic               err_mismatch;
    logic [IDX_W-1:0]   err_vec;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_en, cfg_mask,
        input  clr_valid, clr_idx, evt_ready, ovf_clr, cnt_idx,
        output pending, intr_any, evt_valid, evt_vec, evt_ovf, cnt_val,
        output err_mismatch, err_vec
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_en, cfg_mask,
        output clr_valid, clr_idx, evt_ready, ovf_clr, cnt_idx,
        input  pending, intr_any, evt_valid, evt_vec, evt_ovf, cnt_val,
        input  err_mismatch, err_vec
    );
endinterface

// File: rtl/host_msix_monitor.sv
// rtl/host_msix_monitor.sv - MSI-X write snooper: table match, pending, hit counters, event FIFO (opt. MSIX_DATA_MISMATCH_EN)
module host_msix_monitor #(
    parameter int NUM_VEC    = 8,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    host_msix_monitor_if.slave   mon
);
    localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0]  tbl_addr_q [NUM_VEC];
    logic [DATA_W-1:0]  tbl_data_q [NUM_VEC];
    logic [NUM_VEC-1:0] tbl_en_q;
    logic [NUM_VEC-1:0] tbl_mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
            tbl_en_q   <= '0;
            tbl_mask_q <= '0;
        end else if (mon.cfg_we && (int'(mon.cfg_idx) < NUM_VEC)) begin
            tbl_addr_q[mon.cfg_idx] <= mon.cfg_addr;
            tbl_data_q[mon.cfg_idx] <= mon.cfg_data;
            tbl_en_q[mon.cfg_idx]   <= mon.cfg_en;
            tbl_mask_q[mon.cfg_idx] <= mon.cfg_mask;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    logic             hit_d, s1_hit_q;
    logic [IDX_W-1:0] hit_idx_d, s1_idx_q;

    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (mon.wr_valid && tbl_en_q[i] &&
                (tbl_addr_q[i] == mon.wr_addr) && (tbl_data_q[i] == mon.wr_data)) begin
                hit_d     = 1'b1;
                hit_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hit_q <= 1'b0;
            s1_idx_q <= '0;
        end else begin
            s1_hit_q <= hit_d;
            s1_idx_q <= hit_idx_d;
        end
    end

    // Stage 2: a set from the pipeline overrides a same-cycle clear.
    logic [NUM_VEC-1:0] pending_d, pending_q;

    always_comb begin
        pending_d = pending_q;
        if (mon.clr_valid && (int'(mon.clr_idx) < NUM_VEC))
            pending_d[mon.clr_idx] = 1'b0;
        if (s1_hit_q)
            pending_d[s1_idx_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    logic [CNT_W-1:0] cnt_q [NUM_VEC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) cnt_q[i] <= '0;
        end else if (s1_hit_q && (cnt_q[s1_idx_q] != CNT_MAX)) begin
            cnt_q[s1_idx_q] <= cnt_q[s1_idx_q] + 1'b1;
        end
    end

    logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             ovf_q;
    logic             fifo_empty, fifo_full, do_pop, do_push, do_drop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign do_pop     = !fifo_empty && mon.evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push    = s1_hit_q && (!fifo_full || do_pop);
    assign do_drop    = s1_hit_q && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr_q] <= s1_idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (do_drop)          ovf_q <= 1'b1;
            else if (mon.ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign mon.pending   = pending_q;
    assign mon.intr_any  = |(pending_q & ~tbl_mask_q);
    assign mon.evt_valid = !fifo_empty;
    assign mon.evt_vec   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    assign mon.evt_ovf   = ovf_q;
    assign mon.cnt_val   = (int'(mon.cnt_idx) < NUM_VEC) ? cnt_q[mon.cnt_idx] : '0;

`ifdef MSIX_DATA_MISMATCH_EN
    logic             mm_d, s1_mm_q, err_q;
    logic [IDX_W-1:0] mm_idx_d, s1_mm_idx_q, err_vec_q;

    always_comb begin
        mm_d     = 1'b0;
        mm_idx_d = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (mon.wr_valid && tbl_en_q[i] &&
                (tbl_addr_q[i] == mon.wr_addr) && (tbl_data_q[i] != mon.wr_data)) begin
                mm_d     = 1'b1;
                mm_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_mm_q     <= 1'b0;
            s1_mm_idx_q <= '0;
            err_q       <= 1'b0;
            err_vec_q   <= '0;
        end else begin
            s1_mm_q     <= mm_d;
            s1_mm_idx_q <= mm_idx_d;
            if (s1_mm_q && !s1_hit_q && !err_q) begin
                err_q     <= 1'b1;
                err_vec_q <= s1_mm_idx_q;
            end
        end
    end

    assign mon.err_mismatch = err_q;
    assign mon.err_vec      = err_vec_q;
`else
    assign mon.err_mismatch = 1'b0;
    assign mon.err_vec      = '0;
`endif
endmodule

// File: tb/tb_host_msix_monitor.sv
// tb/tb_host_msix_monitor.sv - scoreboard bench for host_msix_monitor
module tb_host_msix_monitor;
    localparam int NV = 8;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int FD = 8;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    host_msix_monitor_if #(.NUM_VEC(NV), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    host_msix_monitor #(
        .NUM_VEC(NV), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] m_addr [NV];
    logic [DW-1:0] m_data [NV];
    bit            m_en   [NV];
    logic [NV-1:0] m_pend;
    int            m_cnt  [NV];
    bit            m_ovf;
    int            exp_q  [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int i = 0; i < NV; i++)
            if (m_en[i] && m_addr[i] == a && m_data[i] == d) return i;
        return -1;
    endfunction

    task automatic model_event(input int v);
        if (v >= 0) begin
            m_pend[v] = 1'b1;
            if (m_cnt[v] < CMAX) m_cnt[v]++;
            if (exp_q.size() < FD) exp_q.push_back(v);
            else                   m_ovf = 1'b1;
        end
    endtask

    task automatic cfg(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit en, input bit mask);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = 3'(idx);
        bus.cfg_addr = a;
        bus.cfg_data = d;
        bus.cfg_en   = en;
        bus.cfg_mask = mask;
        tick();
        bus.cfg_we   = 1'b0;
        m_addr[idx]  = a;
        m_data[idx]  = d;
        m_en[idx]    = en;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        model_event(model_hit(a, d));
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic clear(input int idx);
        bus.clr_valid = 1'b1;
        bus.clr_idx   = 3'(idx);
        tick();
        bus.clr_valid = 1'b0;
        m_pend[idx]   = 1'b0;
    endtask

    task automatic read_cnt(input string tag, input int idx);
        bus.cnt_idx = 3'(idx);
        #1;
        check_eq(tag, 64'(bus.cnt_val), 64'(m_cnt[idx]));
    endtask

    task automatic drain();
        bus.evt_ready = 1'b1;
        for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
            if (bus.evt_valid) check_eq("evt_vec_order", 64'(bus.evt_vec), 64'(exp_q.pop_front()));
            tick();
        end
        bus.evt_ready = 1'b0;
        check_eq("drain_budget", 64'(exp_q.size()), 64'd0);
        check_eq("evt_valid_after_drain", 64'(bus.evt_valid), 64'd0);
    endtask

    task automatic pulse_ovf_clr();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_addr[i] = '0; m_data[i] = '0; m_en[i] = 1'b0; m_cnt[i] = 0;
        end
        m_pend = '0;
        m_ovf  = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.cfg_en = 0; bus.cfg_mask = 0; bus.clr_valid = 0; bus.clr_idx = '0;
        bus.evt_ready = 0; bus.ovf_clr = 0; bus.cnt_idx = '0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();

        check_eq("rst_pending",   64'(bus.pending), 64'd0);
        check_eq("rst_intr_any",  64'(bus.intr_any), 64'd0);
        check_eq("rst_evt_valid", 64'(bus.evt_valid), 64'd0);
        check_eq("rst_evt_vec",   64'(bus.evt_vec), 64'd0);
        check_eq("rst_evt_ovf",   64'(bus.evt_ovf), 64'd0);
        check_eq("rst_err",       64'(bus.err_mismatch), 64'd0);
        check_eq("rst_err_vec",   64'(bus.err_vec), 64'd0);
        read_cnt("rst_cnt0", 0);

        // single hit on entry 0, two-edge latency
        cfg(0, 64'h1, 32'h1234_5678, 1, 0);
        drive_write(64'h1, 32'h1234_5678);
        check_eq("lat_pending_early", 64'(bus.pending), 64'd0);
        tick();
        check_eq("t1_pending",   64'(bus.pending), 64'(m_pend));
        check_eq("t1_intr_any",  64'(bus.intr_any), 64'd1);
        check_eq("t1_evt_valid", 64'(bus.evt_valid), 64'd1);
        check_eq("t1_evt_vec",   64'(bus.evt_vec), 64'd0);
        read_cnt("t1_cnt0", 0);
        drain();
        clear(0);

        // duplicate entries: lowest index wins
        cfg(2, 64'h1000, 32'hAB, 1, 0);
        cfg(5, 64'h1000, 32'hAB, 1, 0);
        drive_write(64'h1000, 32'hAB);
        tick();
        check_eq("dup_pending", 64'(bus.pending), 64'(m_pend));
        read_cnt("dup_cnt5", 5);
        read_cnt("dup_cnt2", 2);
        drain();
        clear(2);
        drive_write(64'h9999, 32'hAB);
        tick();
        check_eq("miss_pending", 64'(bus.pending), 64'd0);
        check_eq("miss_evt_valid", 64'(bus.evt_valid), 64'd0);

        // masked entry
        cfg(3, 64'h3000, 32'h33, 1, 1);
        drive_write(64'h3000, 32'h33);
        tick();
        check_eq("mask_pending", 64'(bus.pending), 64'(m_pend));
        check_eq("mask_intr_any", 64'(bus.intr_any), 64'd0);
        cfg(3, 64'h3000, 32'h33, 1, 0);
        check_eq("unmask_intr_any", 64'(bus.intr_any), 64'd1);
        check_eq("unmask_keeps_pending", 64'(bus.pending), 64'(m_pend));
        clear(3);
        check_eq("clr3_pending", 64'(bus.pending), 64'd0);
        check_eq("clr3_intr_any", 64'(bus.intr_any), 64'd0);
        drain();

        // overflow: 9 back-to-back hits with no pops
        for (int i = 0; i < 9; i++) begin
            case (i % 3)
                0:       drive_write(64'h1,    32'h1234_5678);
                1:       drive_write(64'h1000, 32'hAB);
                default: drive_write(64'h3000, 32'h33);
            endcase
        end
        tick();
        check_eq("ovf_set",       64'(bus.evt_ovf), 64'(m_ovf));
        check_eq("ovf_pending",   64'(bus.pending), 64'(m_pend));
        check_eq("ovf_evt_valid", 64'(bus.evt_valid), 64'd1);
        drain();
        check_eq("ovf_sticky", 64'(bus.evt_ovf), 64'd1);
        pulse_ovf_clr();
        check_eq("ovf_clr", 64'(bus.evt_ovf), 64'(m_ovf));
        clear(0); clear(2); clear(3);

        // full FIFO: push and pop in the same cycle
        for (int i = 0; i < FD; i++) drive_write(64'h1, 32'h1234_5678);
        tick();
        check_eq("full_no_ovf", 64'(bus.evt_ovf), 64'd0);
        bus.wr_valid = 1'b1; bus.wr_addr = 64'h1000; bus.wr_data = 32'hAB;
        tick();
        bus.wr_valid  = 1'b0;
        bus.evt_ready = 1'b1;
        check_eq("full_pushpop_head", 64'(bus.evt_vec), 64'(exp_q.pop_front()));
        model_event(2);
        tick();
        bus.evt_ready = 1'b0;
        check_eq("full_pushpop_ovf", 64'(bus.evt_ovf), 64'd0);
        drain();
        clear(0); clear(2);

        // counter saturation and set-beats-clear
        cfg(1, 64'h4000, 32'h44, 1, 0);
        for (int i = 0; i < 20; i++) drive_write(64'h4000, 32'h44);
        tick();
        read_cnt("sat_cnt1", 1);
        check_eq("sat_ovf", 64'(bus.evt_ovf), 64'(m_ovf));
        drain();
        pulse_ovf_clr();
        bus.wr_valid = 1'b1; bus.wr_addr = 64'h4000; bus.wr_data = 32'h44;
        model_event(1);
        tick();
        bus.wr_valid  = 1'b0;
        bus.clr_valid = 1'b1;
        bus.clr_idx   = 3'd1;
        tick();
        bus.clr_valid = 1'b0;
        check_eq("set_wins_pending", 64'(bus.pending), 64'(m_pend));
        read_cnt("sat_hold_cnt1", 1);
        drain();

        // reset with a hit in flight
        bus.wr_valid = 1'b1; bus.wr_addr = 64'h4000; bus.wr_data = 32'h44;
        tick();
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        tick(); tick();
        check_eq("midrst_pending", 64'(bus.pending), 64'd0);
        check_eq("midrst_evt_valid", 64'(bus.evt_valid), 64'd0);
        read_cnt("midrst_cnt1", 1);

        // address match, data mismatch
        cfg(4, 64'h2000, 32'h55, 1, 0);
        drive_write(64'h2000, 32'h56);
        tick();
        check_eq("mm_pending", 64'(bus.pending), 64'd0);
        check_eq("mm_evt_valid", 64'(bus.evt_valid), 64'd0);
`ifdef MSIX_DATA_MISMATCH_EN
        check_eq("mm_err", 64'(bus.err_mismatch), 64'd1);
        check_eq("mm_err_vec", 64'(bus.err_vec), 64'd4);
`else
        check_eq("mm_err_off", 64'(bus.err_mismatch), 64'd0);
        check_eq("mm_err_vec_off", 64'(bus.err_vec), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
